// File: rtl/fifo_byte_packer.sv
// Pops bytes from a FIFO read port and packs them LSB-first into BYTES-wide words,
// with flush-driven partial words, a valid/ready output handshake and a word counter.
module fifo_byte_packer #(
  parameter int BYTES = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rempty,
  output logic                 read_enable,
  input  logic [7:0]           rdata,
  input  logic                 flush,
  output logic [8*BYTES-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_bytes,
  output logic                 out_last,
  output logic [15:0]          word_cnt
);

  localparam int OUT_W = 8 * BYTES;
  localparam logic [3:0] BYTES_L = 4'(BYTES);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_count;
  logic             r_inflight;
  logic             r_flush_pend;
  logic [OUT_W-1:0] r_data;
  logic [3:0]       r_bytes;
  logic             r_last;
  logic [15:0]      r_word_cnt;

  logic       w_fill;
  logic [3:0] w_level;

  // Bytes already in the word plus the one whose data arrives this cycle.
  assign w_fill  = (r_state == ST_FILL);
  assign w_level = r_count + {3'b000, r_inflight};

  assign read_enable = !rrst && w_fill && !rempty && !r_flush_pend && (w_level < BYTES_L);

  assign out_data  = r_data;
  assign out_valid = (r_state == ST_HOLD);
  assign out_bytes = r_bytes;
  assign out_last  = r_last;
  assign word_cnt  = r_word_cnt;

  // NOTE: state registers use non-blocking assignments so every branch below reads
  // the values from before this edge, regardless of statement order.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state      <= ST_FILL;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_bytes      <= '0;
      r_last       <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_inflight <= read_enable;
      case (r_state)
        ST_FILL: begin
          if (r_inflight) begin
            r_data[{r_count[2:0], 3'b000} +: 8] <= rdata;
            r_count <= w_level;
          end
          if (w_level == BYTES_L) begin
            r_state <= ST_HOLD;
            r_bytes <= BYTES_L;
            r_last  <= r_flush_pend;
          end else if (r_flush_pend) begin
            if (w_level != 4'd0) begin
              r_state <= ST_HOLD;
              r_bytes <= w_level;
              r_last  <= 1'b1;
            end else begin
              r_flush_pend <= 1'b0;
            end
          end
        end
        default: begin
          if (out_ready) begin
            r_state      <= ST_FILL;
            r_count      <= '0;
            r_data       <= '0;
            r_bytes      <= '0;
            r_last       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_word_cnt   <= r_word_cnt + 16'd1;
          end
        end
      endcase
      // A fresh flush request is never dropped, even on a clearing edge.
      if (flush) r_flush_pend <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_byte_packer.md
FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 SHALL have parameter: BYTES, 4, bytes per output word; legal range 2..8; OUT_W = 8*BYTES.
REQ-002 SHALL have port: rclk  input  1  single clock; the FIFO read-side clock.
REQ-003 SHALL have port: rrst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: rempty  input  1  FIFO read-side empty flag.
REQ-005 SHALL have port: read_enable  output  1  FIFO pop request.
REQ-006 SHALL have port: rdata  input  8  FIFO read data, valid on the rclk edge after an accepted pop.
REQ-007 SHALL have port: flush  input  1  one-cycle request to emit a partial word.
REQ-008 SHALL have port: out_data  output  OUT_W  packed word.
REQ-009 SHALL have port: out_valid  output  1  word available.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the word.
REQ-011 SHALL have port: out_bytes  output  4  count of valid bytes in out_data (1..BYTES).
REQ-012 SHALL have port: out_last  output  1  word was closed by a flush.
REQ-013 SHALL have port: word_cnt  output  16  count of emitted words, modulo 2^16.

Function
REQ-014 SHALL implement two states: FILL (collecting bytes) and HOLD (presenting a word).
REQ-015 SHALL drive read_enable combinationally as: state==FILL && !rempty && !flush_pend && (count + inflight) < BYTES.
REQ-016 SHALL define an accepted pop as read_enable=1 at a rclk edge, which sets the inflight flag for exactly one cycle.
REQ-017 SHALL, on the cycle after an accepted pop (inflight=1), capture rdata into byte lane count (bits 8*count+7 : 8*count), LSB-first, and increment count.
REQ-018 SHALL allow back-to-back pops: one byte per cycle sustained while rempty=0.
REQ-019 SHALL enter HOLD on the edge where count becomes BYTES, with out_bytes=BYTES.
REQ-020 SHALL, in HOLD, assert out_valid=1 and keep out_data, out_bytes and out_last stable until out_valid && out_ready; no pops in HOLD.
REQ-021 SHALL, on handshake: clear count, zero out_data, increment word_cnt (wrap FFFF->0000), clear flush_pend, return to FILL; next pop no earlier than the following cycle.
REQ-022 SHALL set flush_pend on any cycle with flush=1; flush_pend stays set until the next handshake.
REQ-023 SHALL, when flush_pend=1 in FILL with inflight=0 and count>0, enter HOLD with out_bytes=count, out_last=1 and unfilled lanes zero.
REQ-024 SHALL, when flush_pend=1 and inflight=1, capture the in-flight byte first and then apply REQ-023 (or REQ-025 if the word completes).
REQ-025 SHALL, when a word reaches BYTES while flush_pend=1, set out_last=1 on that word.
REQ-026 SHALL, for flush with count=0 and inflight=0, drop flush_pend in FILL the next cycle, emitting nothing.
REQ-027 SHALL, if rempty asserts while inflight=1, still capture the in-flight byte; the captured value is never lost or duplicated.

Reset
REQ-028 SHALL, while rrst=1 at a rclk edge, set state FILL, count 0, inflight 0, flush_pend 0, out_data 0, out_valid 0, out_bytes 0, out_last 0, word_cnt 0; read_enable SHALL be 0 during reset.
REQ-029 SHALL discard partial words and any in-flight byte on reset mid-operation; the FIFO side is reset by its own rrst.

Verification
REQ-030 SHALL cover basic pack: FIFO holds 01,02,03,04, out_ready=1 -> out_data=32'h04030201, out_bytes=4, out_last=0, word_cnt=1, four consecutive read_enable cycles.
REQ-031 SHALL cover backpressure: 8 bytes 01..08, out_ready=0 for 10 cycles -> out_data held at 32'h04030201, read_enable=0 throughout HOLD; after ready, second word 32'h08070605.
REQ-032 SHALL cover flush partial: bytes 11,12 then flush pulse -> out_data=32'h00001211, out_bytes=2, out_last=1.
REQ-033 SHALL cover rempty gaps: rempty toggling every cycle with bytes A1..A4 -> single word 32'hA4A3A2A1; read_enable never high while rempty=1.
REQ-034 SHALL cover reset mid-fill: 3 bytes captured, rrst pulse, then bytes 21..24 -> out_data=32'h24232221, word_cnt=1.
REQ-035 SHALL cover counter wrap: word_cnt preloaded to 16'hFFFF via 65535 words (or forced) -> next handshake gives 16'h0000.
